// File: rtl/pwm_deadtime_modulator.sv
// Center-aligned PWM from a triangle count, split into complementary high/low drives with dead time.
// Optional build macro PWM_ABORT_FLAG_EN adds the sticky short_pulse abort flag output.
module pwm_deadtime_modulator #(
    parameter int N    = 8,
    parameter int DT_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [N-1:0]    tri_in,
    input  logic [N-1:0]    duty_in,
    input  logic            duty_valid,
    output logic            duty_ready,
    input  logic [DT_W-1:0] deadtime,
    output logic            out_hi,
    output logic            out_lo,
    output logic            valley,
    output logic [1:0]      state_dbg
`ifdef PWM_ABORT_FLAG_EN
    ,
    output logic            short_pulse
`endif
);

    typedef enum logic [1:0] {
        LO_ON   = 2'd0,
        DT_RISE = 2'd1,
        HI_ON   = 2'd2,
        DT_FALL = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [DT_W-1:0] dt_cnt;
    logic [DT_W-1:0] dt_cnt_nxt;
    logic [N-1:0]    duty_active;
    logic [N-1:0]    pending;
    logic            pending_full;
    logic            raw;
    logic            at_valley;
    logic            accept;
    logic            load;

    // Handshake: a duty word transfers on any clk edge where duty_valid && duty_ready;
    // duty_ready depends only on the pending slot, never on duty_valid.
    assign duty_ready = !pending_full;
    assign accept     = duty_valid && duty_ready;
    assign at_valley  = ena && (tri_in == '0);
    assign load       = at_valley && pending_full;

    // accept needs an empty slot and load needs a full one, so they never coincide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending      <= '0;
            pending_full <= 1'b0;
            duty_active  <= '0;
        end else if (load) begin
            duty_active  <= pending;
            pending_full <= 1'b0;
        end else if (accept) begin
            pending      <= duty_in;
            pending_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw    <= 1'b0;
            valley <= 1'b0;
        end else begin
            valley <= at_valley;
            if (ena) begin
                raw <= (tri_in < duty_active);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= DT_FALL;
            dt_cnt <= '0;
        end else begin
            state  <= state_nxt;
            dt_cnt <= dt_cnt_nxt;
        end
    end

    // Dead-time states fall back to the side they came from if raw reverts before the gap ends
    always_comb begin
        state_nxt  = state;
        dt_cnt_nxt = dt_cnt;
        case (state)
            LO_ON: begin
                if (raw) begin
                    state_nxt  = DT_RISE;
                    dt_cnt_nxt = deadtime;
                end
            end
            DT_RISE: begin
                if (!raw) begin
                    state_nxt = LO_ON;
                end else if (dt_cnt == '0) begin
                    state_nxt = HI_ON;
                end else begin
                    dt_cnt_nxt = dt_cnt - DT_W'(1);
                end
            end
            HI_ON: begin
                if (!raw) begin
                    state_nxt  = DT_FALL;
                    dt_cnt_nxt = deadtime;
                end
            end
            DT_FALL: begin
                if (raw) begin
                    state_nxt = HI_ON;
                end else if (dt_cnt == '0) begin
                    state_nxt = LO_ON;
                end else begin
                    dt_cnt_nxt = dt_cnt - DT_W'(1);
                end
            end
            default: begin
                state_nxt  = DT_FALL;
                dt_cnt_nxt = '0;
            end
        endcase
    end

    assign out_hi    = (state == HI_ON);
    assign out_lo    = (state == LO_ON);
    assign state_dbg = state;

`ifdef PWM_ABORT_FLAG_EN
    logic abort;

    assign abort = ((state == DT_RISE) && !raw) || ((state == DT_FALL) && raw);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            short_pulse <= 1'b0;
        end else if (abort) begin
            short_pulse <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pwm_deadtime_modulator.sv
// Randomized bench for pwm_deadtime_modulator against a run-length reference model of the dead-time rules.
module tb_pwm_deadtime_modulator;

    localparam int N    = 8;
    localparam int DT_W = 4;
    localparam int TMAX = (1 << N) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            ena = 1'b0;
    logic [N-1:0]    tri_in = '0;
    logic [N-1:0]    duty_in = '0;
    logic            duty_valid = 1'b0;
    logic [DT_W-1:0] deadtime = '0;
    logic            duty_ready;
    logic            out_hi;
    logic            out_lo;
    logic            valley;
    logic [1:0]      state_dbg;
`ifdef PWM_ABORT_FLAG_EN
    logic            short_pulse;
`endif

    pwm_deadtime_modulator #(.N(N), .DT_W(DT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .tri_in     (tri_in),
        .duty_in    (duty_in),
        .duty_valid (duty_valid),
        .duty_ready (duty_ready),
        .deadtime   (deadtime),
        .out_hi     (out_hi),
        .out_lo     (out_lo),
        .valley     (valley),
        .state_dbg  (state_dbg)
`ifdef PWM_ABORT_FLAG_EN
        ,
        .short_pulse(short_pulse)
`endif
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // reference model: pending slot queue, active duty, raw compare and a side/run-length view of dead time
    logic [N-1:0] pend_q[$];
    logic [N-1:0] m_duty;
    bit           m_raw;
    bit           m_valley;
    bit           m_side_hi;
    bit           m_flag;
    int           m_run;
    int           dt_val;

    int  tri_pos;
    bit  tri_up;
    bit  gap_en = 1'b0;
    int  gap_len;
    bit  hi_seen;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend_q.delete();
        m_duty    = '0;
        m_raw     = 1'b0;
        m_valley  = 1'b0;
        m_flag    = 1'b0;
        // reset looks like the last gap sample of a falling transition
        m_side_hi = 1'b1;
        m_run     = dt_val + 1;
    endtask

    task automatic model_edge();
        bit was_empty;
        if (m_raw != m_side_hi) begin
            m_run++;
            if (m_run >= dt_val + 2) begin
                m_side_hi = m_raw;
                m_run     = 0;
            end
        end else begin
            if (m_run > 0) m_flag = 1'b1;
            m_run = 0;
        end
        m_valley = ena && (tri_in == 0);
        if (ena) m_raw = (tri_in < m_duty);
        was_empty = (pend_q.size() == 0);
        if (m_valley && !was_empty) m_duty = pend_q.pop_front();
        if (duty_valid && was_empty) pend_q.push_back(duty_in);
    endtask

    task automatic check_outputs();
        check("out_hi", int'(out_hi), int'(m_side_hi && m_run == 0));
        check("out_lo", int'(out_lo), int'(!m_side_hi && m_run == 0));
        check("overlap", int'(out_hi & out_lo), 0);
        check("valley", int'(valley), int'(m_valley));
        check("duty_ready", int'(duty_ready), int'(pend_q.size() == 0));
`ifdef PWM_ABORT_FLAG_EN
        check("short_pulse", int'(short_pulse), int'(m_flag));
`endif
        if (out_hi) hi_seen = 1'b1;
        if (gap_en) begin
            if (!out_hi && !out_lo) begin
                gap_len++;
            end else begin
                if (gap_len > 0) check("dead_gap", gap_len, dt_val + 1);
                gap_len = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        if (ena) begin
            if (tri_up) begin
                if (tri_pos == TMAX) begin
                    tri_up  = 1'b0;
                    tri_pos = TMAX - 1;
                end else begin
                    tri_pos++;
                end
            end else begin
                if (tri_pos == 0) begin
                    tri_up  = 1'b1;
                    tri_pos = 1;
                end else begin
                    tri_pos--;
                end
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive_random(input int ena_pct, input int valid_pct);
        ena        = ($urandom_range(99) < ena_pct);
        duty_valid = ($urandom_range(99) < valid_pct);
        case ($urandom_range(7))
            0:       duty_in = '0;
            1:       duty_in = N'(TMAX);
            default: duty_in = N'($urandom_range(TMAX));
        endcase
        tri_in = N'(tri_pos);
    endtask

    task automatic reset_dut(input int dt);
        @(negedge clk);
        rst        = 1'b0;
        ena        = 1'b0;
        duty_valid = 1'b0;
        deadtime   = DT_W'(dt);
        dt_val     = dt;
        model_reset();
        tri_pos = 5;
        tri_up  = 1'b0;
        tri_in  = N'(tri_pos);
        #1;
        check("rst_out_hi", int'(out_hi), 0);
        check("rst_out_lo", int'(out_lo), 0);
        check("rst_valley", int'(valley), 0);
        check("rst_duty_ready", int'(duty_ready), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_fixed(input int dt, input int duty, input int cycles, input bit gap_chk);
        reset_dut(dt);
        gap_en  = gap_chk;
        gap_len = 0;
        hi_seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            ena        = 1'b1;
            tri_in     = N'(tri_pos);
            duty_valid = (i == 0);
            duty_in    = N'(duty);
            step();
        end
        gap_en = 1'b0;
    endtask

    initial begin
        bit found;

        // steady PWM with exact dead gaps
        run_fixed(3, 100, 1200, 1'b1);

        // zero duty over a full period keeps the low side on
        run_fixed(5, 0, 520, 1'b0);
        check("duty0_no_hi", int'(hi_seen), 0);

        // narrow pulse shorter than the dead time aborts every rise
        run_fixed(15, 2, 1100, 1'b0);
        check("narrow_no_hi", int'(hi_seen), 0);
`ifdef PWM_ABORT_FLAG_EN
        check("narrow_flag", int'(short_pulse), 1);
`endif

        for (int p = 0; p < 6; p++) begin
            int ena_pct;
            int valid_pct;
            reset_dut(int'($urandom_range(15)));
            ena_pct   = int'($urandom_range(30, 100));
            valid_pct = int'($urandom_range(2, 40));
            for (int i = 0; i < 1500; i++) begin
                drive_random(ena_pct, valid_pct);
                step();
            end
        end

        // asynchronous reset while driving high with a word pending
        reset_dut(2);
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (i == 0) begin
                ena        = 1'b1;
                duty_valid = 1'b1;
                duty_in    = 8'd200;
                tri_in     = N'(tri_pos);
            end else begin
                drive_random(100, 60);
                if (duty_in < 8'd100) duty_in = 8'd150;
            end
            step();
            if (m_side_hi && m_run == 0 && pend_q.size() == 1) found = 1'b1;
        end
        check("reach_hi_pending", int'(found), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_out_hi", int'(out_hi), 0);
        check("async_out_lo", int'(out_lo), 0);
        check("async_duty_ready", int'(duty_ready), 1);
        model_reset();
        @(negedge clk);
        rst        = 1'b1;
        ena        = 1'b1;
        duty_valid = 1'b0;
        tri_in     = N'(tri_pos);
        step();
        check("lo_after_release", int'(out_lo), 1);
        hi_seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            ena        = 1'b1;
            duty_valid = 1'b0;
            tri_in     = N'(tri_pos);
            step();
        end
        check("pending_discarded", int'(hi_seen), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_modulator.md
Name: pwm_deadtime_modulator

Overview:
Downstream consumer of the triangle generator's count. Compares the triangle value against a double-buffered duty word to produce center-aligned PWM, then splits it into complementary high-side/low-side drives with programmable dead time. Duty updates arrive over a valid/ready handshake and take effect only at the triangle valley (count 0), so a period is never glitched mid-cycle.

Parameters:
N, 8, width of triangle count and duty word
DT_W, 4, width of dead-time count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ena  in  1  step strobe; same strobe that advances the triangle generator
tri_in  in  N  triangle count
duty_in  in  N  new duty word
duty_valid  in  1  duty_in valid
duty_ready  out  1  block can accept a duty word
deadtime  in  DT_W  dead-time length in clk cycles, quasi-static
out_hi  out  1  high-side drive
out_lo  out  1  low-side drive
valley  out  1  1-clk pulse when the triangle valley is sampled

Behaviour:
- Reset (rst=0, async): duty_active=0, pending empty, raw=0, valley=0, FSM=DT_FALL with dt_cnt=0, out_hi=out_lo=0.
- duty_ready = !pending_full (combinational); it is 1 during and after reset.
- Accept: when duty_valid & duty_ready at a clk edge, pending<=duty_in and pending_full<=1.
- Valley load: when ena & tri_in==0 & pending_full, duty_active<=pending and pending_full<=0.
- Accept and valley in the same cycle with pending empty: the word goes to pending only; it loads at the next valley.
- Valley output: valley<=ena & (tri_in==0), registered, 1 clk wide.
- Compare: on ena, raw<=(tri_in < duty_active), unsigned; raw holds while ena=0. The compare uses the pre-load duty_active in the valley cycle.
- FSM: 4 states, Moore outputs. out_hi=(state==HI_ON); out_lo=(state==LO_ON). Both outputs are low in the DT states.
- FSM clocking: it advances every clk, not gated by ena. dt_cnt counts clk cycles.
  LO_ON: raw=1 -> DT_RISE, dt_cnt<=deadtime.
  DT_RISE: raw=0 -> LO_ON (abort); else dt_cnt==0 -> HI_ON; else dt_cnt--.
  HI_ON: raw=0 -> DT_FALL, dt_cnt<=deadtime.
  DT_FALL: raw=1 -> HI_ON (abort); else dt_cnt==0 -> LO_ON; else dt_cnt--.
- Dead gap: both outputs stay low for exactly deadtime+1 clk on every completed transition. deadtime=0 gives a 1-clk gap.
- Latency: raw changes 1 clk after the ena edge. The FSM leaves LO_ON/HI_ON 1 clk after raw changes.
- Safety: out_hi & out_lo is never 1 in any state, including across reset.
- After reset release: DT_FALL with cnt 0 and raw 0 -> LO_ON, so out_lo=1 after the first edge.
- duty_active=0: raw is always 0 and out_lo stays 1 permanently.
- duty_active=2^N-1: raw=0 only at tri_in=2^N-1.
- Reset mid-operation: both outputs drop asynchronously. Any pending word is discarded.

Optional Feature:
Macro PWM_ABORT_FLAG_EN.
- Defined: adds output port short_pulse (1 bit). It is a sticky flag set on any DT_RISE->LO_ON or DT_FALL->HI_ON abort. It is cleared only by reset, and reads 0 at reset.
- Undefined: the port and its logic are absent. Aborts are silent. All other behaviour is identical.

Test Plan:
1. N=8, deadtime=3, duty=100 loaded, ena every clk, triangle running -> at each raw edge both outputs are low for exactly 4 clk; out_hi and out_lo are never both 1.
2. Duty 100 accepted at tri_in=50 on the up-slope -> duty_ready=0 next clk; duty_active stays at its old value until ena & tri_in==0; then valley pulses, duty_ready=1 and duty_active=100.
3. Pending holds 100 and duty_valid presents 200 -> 200 is not accepted (ready=0) until after the valley load. The next valley loads 200.
4. duty=0 over a full period (510 ena) -> out_lo=1 throughout, out_hi=0 throughout; short_pulse stays 0 if PWM_ABORT_FLAG_EN is defined.
5. deadtime=15, duty=2 -> raw is high for 3 ena (tri 1,0,1); the FSM aborts from DT_RISE and out_hi never asserts. short_pulse=1 if the macro is defined.
6. Pull rst low while in HI_ON with a pending word -> out_hi=out_lo=0 immediately (before the next clk), and duty_ready=1. After release, out_lo=1 after 1 clk and duty_active=0.
